frame_header_writer: RTL and testbench



---
 rtl/zstd_pkg.sv | 61 ++++++
 rtl/fcs_field_encoder.sv | 63 ++++++
 rtl/frame_header_writer.sv | 172 +++++++++++++++++
 tb/tb_frame_header_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zstd_pkg.sv
// Shared Zstandard frame-header definitions.
//
// Holds the frame magic number, Frame_Header_Descriptor bit positions, the
// header writer state encoding, the field-size helper functions and the
// packed "sizes" layout that both the header writer and the header parser use.
package zstd_pkg;

  localparam logic [31:0] ZSTD_MAGIC = 32'hFD2FB528;

  // Frame_Header_Descriptor bit positions.
  localparam int unsigned FHD_FCS_FLAG_LSB = 6;
  localparam int unsigned FHD_SS_BIT       = 5;
  localparam int unsigned FHD_UNUSED_BIT   = 4;
  localparam int unsigned FHD_RESERVED_BIT = 3;
  localparam int unsigned FHD_CHECKSUM_BIT = 2;
  localparam int unsigned FHD_DID_FLAG_LSB = 0;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } hdr_state_e;

  // {WD present, DID byte count, FCS byte count}; matches the parser's view.
  typedef struct packed {
    logic       wd_present;
    logic [2:0] did_bytes;
    logic [3:0] fcs_bytes;
  } hdr_sizes_t;

  function automatic logic [1:0] did_flag_from_id(input logic [31:0] id);
    if (id == 32'd0) begin
      return 2'd0;
    end else if (id < 32'd256) begin
      return 2'd1;
    end else if (id < 32'd65536) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [2:0] did_bytes_from_flag(input logic [1:0] flag);
    case (flag)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] fcs_bytes_from_flag(input logic [1:0] flag,
                                                     input logic       single_segment);
    case (flag)
      2'd0:    return single_segment ? 4'd1 : 4'd0;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/fcs_field_encoder.sv
// Frame_Content_Size field encoder (combinational).
//
// Chooses (or validates) the FCS flag, gives the field byte count and the
// value as stored on the wire (the 2-byte form carries value-256).
// Macro FCS_AUTO_SIZE_EN: when defined the flag is chosen minimally from the
// value and flag_in is ignored; invalid is then always 0.
//
// Ports:
//   value_in       in  64  content size value
//   single_segment in  1   Single_Segment_flag
//   flag_in        in  2   requested FCS flag
//   flag_out       out 2   flag written into the FHD
//   nbytes         out 4   FCS field length in bytes
//   value_out      out 64  value to serialize, LSB first
//   invalid        out 1   value cannot be represented with flag_in
module fcs_field_encoder
  import zstd_pkg::*;
(
  input  logic [63:0] value_in,
  input  logic        single_segment,
  input  logic [1:0]  flag_in,
  output logic [1:0]  flag_out,
  output logic [3:0]  nbytes,
  output logic [63:0] value_out,
  output logic        invalid
);

  localparam logic [63:0] Fcs1Max   = 64'd255;
  localparam logic [63:0] FcsOffset = 64'd256;
  localparam logic [63:0] Fcs2Max   = 64'd65791;
  localparam logic [63:0] Fcs4Max   = 64'h0000_0000_FFFF_FFFF;

`ifdef FCS_AUTO_SIZE_EN
  logic unused_flag_in;
  assign unused_flag_in = ^flag_in;
`endif

  always_comb begin
    flag_out = flag_in;
    invalid  = 1'b0;
`ifdef FCS_AUTO_SIZE_EN
    if (single_segment && (value_in <= Fcs1Max)) begin
      flag_out = 2'd0;
    end else if ((value_in >= FcsOffset) && (value_in <= Fcs2Max)) begin
      flag_out = 2'd1;
    end else if (value_in <= Fcs4Max) begin
      flag_out = 2'd2;
    end else begin
      flag_out = 2'd3;
    end
`else
    case (flag_in)
      2'd0:    invalid = single_segment && (value_in > Fcs1Max);
      2'd1:    invalid = (value_in < FcsOffset) || (value_in > Fcs2Max);
      2'd2:    invalid = value_in > Fcs4Max;
      default: invalid = 1'b0;
    endcase
`endif
    nbytes    = fcs_bytes_from_flag(flag_out, single_segment);
    value_out = (flag_out == 2'd1) ? (value_in - FcsOffset) : value_in;
  end

endmodule

// File: rtl/frame_header_writer.sv
// Zstandard frame header writer.
//
// Latches the header fields on start, builds the full header into a byte
// buffer and streams it two bytes per beat (first wire byte in [15:8]) with
// valid/ready handshaking. Optional macro FCS_AUTO_SIZE_EN selects the FCS
// flag automatically (see fcs_field_encoder); error then never fires.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               accepts the field inputs when not busy
//   single_segment, checksum_flag, window_descriptor, dict_id,
//   frame_content_size, fcs_flag_in   header fields
//   out_data/out_valid/out_ready/out_nbytes/out_last   output beat stream
//   sizes               {WD present, DID bytes, FCS bytes} of the last header
//   busy                header in flight
//   error               one-cycle pulse on a rejected start
module frame_header_writer
  import zstd_pkg::*;
#(
  parameter int unsigned MAX_HDR_BYTES = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        single_segment,
  input  logic        checksum_flag,
  input  logic [7:0]  window_descriptor,
  input  logic [31:0] dict_id,
  input  logic [63:0] frame_content_size,
  input  logic [1:0]  fcs_flag_in,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_nbytes,
  output logic        out_last,
  output logic [7:0]  sizes,
  output logic        busy,
  output logic        error
);

  localparam int unsigned IdxW = $clog2(MAX_HDR_BYTES + 1);

  hdr_state_e      state_q, state_d;
  logic [IdxW-2:0] beat_q, beat_d;
  logic [IdxW-1:0] total_q, total_d;
  hdr_sizes_t      sizes_q, sizes_d;
  logic            error_q, error_d;
  logic [7:0]      hdr_q [MAX_HDR_BYTES];
  logic [7:0]      hdr_d [MAX_HDR_BYTES];
  logic            accept;

  logic [1:0]  fcs_flag;
  logic [3:0]  fcs_bytes;
  logic [63:0] fcs_value;
  logic        fcs_invalid;
  logic [1:0]  did_flag;
  logic [2:0]  did_bytes;
  logic [7:0]  fhd;
  logic [IdxW-1:0] pos;

  fcs_field_encoder u_fcs_enc (
    .value_in       (frame_content_size),
    .single_segment (single_segment),
    .flag_in        (fcs_flag_in),
    .flag_out       (fcs_flag),
    .nbytes         (fcs_bytes),
    .value_out      (fcs_value),
    .invalid        (fcs_invalid)
  );

  assign did_flag  = did_flag_from_id(dict_id);
  assign did_bytes = did_bytes_from_flag(did_flag);

  // Header image built straight from the live inputs; captured on accept.
  always_comb begin
    fhd                               = '0;
    fhd[FHD_FCS_FLAG_LSB +: 2]        = fcs_flag;
    fhd[FHD_SS_BIT]                   = single_segment;
    fhd[FHD_CHECKSUM_BIT]             = checksum_flag;
    fhd[FHD_DID_FLAG_LSB +: 2]        = did_flag;

    hdr_d = '{default: '0};
    for (int unsigned i = 0; i < 4; i++) begin
      hdr_d[i] = ZSTD_MAGIC[8*i +: 8];
    end
    hdr_d[4] = fhd;
    pos      = IdxW'(5);
    if (!single_segment) begin
      hdr_d[5] = window_descriptor;
      pos      = IdxW'(6);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < did_bytes) begin
        hdr_d[pos + IdxW'(i)] = dict_id[8*i +: 8];
      end
    end
    pos = pos + IdxW'(did_bytes);
    for (int unsigned i = 0; i < 8; i++) begin
      if (4'(i) < fcs_bytes) begin
        hdr_d[pos + IdxW'(i)] = fcs_value[8*i +: 8];
      end
    end
    total_d = pos + IdxW'(fcs_bytes);

    sizes_d.wd_present = ~single_segment;
    sizes_d.did_bytes  = did_bytes;
    sizes_d.fcs_bytes  = fcs_bytes;
  end

  // Output beat view of the buffer. Bytes past the header end are zero
  // because the buffer is cleared while it is built.
  logic [IdxW-1:0] byte_idx;
  assign byte_idx  = {beat_q, 1'b0};
  assign out_valid = (state_q == StEmit);
  assign out_data  = out_valid ? {hdr_q[byte_idx], hdr_q[byte_idx + IdxW'(1)]} : 16'h0000;
  assign out_last  = out_valid && ((byte_idx + IdxW'(2)) >= total_q);
  assign out_nbytes = !out_valid                        ? 2'd0 :
                      ((byte_idx + IdxW'(1)) == total_q) ? 2'd1 : 2'd2;
  assign busy      = out_valid;
  assign sizes     = sizes_q;
  assign error     = error_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    error_d = 1'b0;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (fcs_invalid) begin
            error_d = 1'b1;
          end else begin
            accept  = 1'b1;
            beat_d  = '0;
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          beat_d = beat_q + 1'b1;
          if (out_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      total_q <= '0;
      sizes_q <= '0;
      error_q <= 1'b0;
      hdr_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      error_q <= error_d;
      if (accept) begin
        hdr_q   <= hdr_d;
        total_q <= total_d;
        sizes_q <= sizes_d;
      end
    end
  end

endmodule

// File: tb/tb_frame_header_writer.sv
module tb_frame_header_writer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        single_segment;
  logic        checksum_flag;
  logic [7:0]  window_descriptor;
  logic [31:0] dict_id;
  logic [63:0] frame_content_size;
  logic [1:0]  fcs_flag_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_nbytes;
  logic        out_last;
  logic [7:0]  sizes;
  logic        busy;
  logic        error;

  frame_header_writer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .single_segment     (single_segment),
    .checksum_flag      (checksum_flag),
    .window_descriptor  (window_descriptor),
    .dict_id            (dict_id),
    .frame_content_size (frame_content_size),
    .fcs_flag_in        (fcs_flag_in),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_nbytes         (out_nbytes),
    .out_last           (out_last),
    .sizes              (sizes),
    .busy               (busy),
    .error              (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  nb;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    n_chk = 0;
  int    n_err = 0;
  bit    mon_en = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference header model: pushes the expected beats, reports rejection.
  task automatic model(input logic ss, input logic chk, input logic [7:0] wd,
                       input logic [31:0] did, input logic [63:0] fcs,
                       input logic [1:0] ffl, output logic err);
    logic [7:0]  b[$];
    int          did_n;
    int          fcs_n;
    logic [1:0]  did_f;
    logic [1:0]  f;
    logic [63:0] v;
    beat_t       bt;
    b = {8'h28, 8'hB5, 8'h2F, 8'hFD};
    if (did == 0)            begin did_f = 2'd0; did_n = 0; end
    else if (did < 256)      begin did_f = 2'd1; did_n = 1; end
    else if (did < 65536)    begin did_f = 2'd2; did_n = 2; end
    else                     begin did_f = 2'd3; did_n = 4; end
    err = 1'b0;
`ifdef FCS_AUTO_SIZE_EN
    if (ss && fcs < 256)                  f = 2'd0;
    else if (fcs >= 256 && fcs <= 65791)  f = 2'd1;
    else if (fcs <= 64'hFFFF_FFFF)        f = 2'd2;
    else                                  f = 2'd3;
`else
    f = ffl;
    if (f == 2'd0 && ss && fcs > 255) err = 1'b1;
    if (f == 2'd1 && (fcs < 256 || fcs > 65791)) err = 1'b1;
    if (f == 2'd2 && fcs > 64'hFFFF_FFFF) err = 1'b1;
`endif
    case (f)
      2'd0:    fcs_n = ss ? 1 : 0;
      2'd1:    fcs_n = 2;
      2'd2:    fcs_n = 4;
      default: fcs_n = 8;
    endcase
    v = (f == 2'd1) ? fcs - 64'd256 : fcs;
    b.push_back({f, ss, 1'b0, 1'b0, chk, did_f});
    if (!ss) b.push_back(wd);
    for (int i = 0; i < did_n; i++) b.push_back(did[8*i +: 8]);
    for (int i = 0; i < fcs_n; i++) b.push_back(v[8*i +: 8]);
    if (!err) begin
      for (int i = 0; i < b.size(); i += 2) begin
        bt.data[15:8] = b[i];
        bt.data[7:0]  = (i + 1 < b.size()) ? b[i+1] : 8'h00;
        bt.nb         = (i + 1 < b.size()) ? 2'd2 : 2'd1;
        bt.last       = (i + 2 >= b.size());
        sb.push_back(bt);
      end
    end
  endtask

  task automatic set_fields(input logic ss, input logic chk, input logic [7:0] wd,
                            input logic [31:0] did, input logic [63:0] fcs,
                            input logic [1:0] ffl);
    single_segment     = ss;
    checksum_flag      = chk;
    window_descriptor  = wd;
    dict_id            = did;
    frame_content_size = fcs;
    fcs_flag_in        = ffl;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the start edge.
  task automatic send(input logic ss, input logic chk, input logic [7:0] wd,
                      input logic [31:0] did, input logic [63:0] fcs,
                      input logic [1:0] ffl, input logic [7:0] exp_sizes);
    logic err;
    set_fields(ss, chk, wd, did, fcs, ffl);
    model(ss, chk, wd, did, fcs, ffl, err);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("error_pulse", error, err);
    check_eq("busy_after_start", busy, !err);
    check_eq("sizes", sizes, exp_sizes);
    if (err) begin
      check_eq("valid_on_error", out_valid, 0);
      @(posedge clk);
      #1;
      check_eq("error_one_cycle", error, 0);
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1;
    end
    check_eq("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, hold check while stalled.
  initial begin
    bit    stalled;
    beat_t held;
    beat_t exp;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (reset_n && mon_en) begin
        if (stalled && out_valid) begin
          check_eq("hold_data", out_data, held.data);
          check_eq("hold_nbytes", out_nbytes, held.nb);
          check_eq("hold_last", out_last, held.last);
        end
        stalled = out_valid && !out_ready;
        held    = {out_data, out_nbytes, out_last};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", sb.size(), 1);
          end else begin
            exp = sb.pop_front();
            check_eq("beat_data", out_data, exp.data);
            check_eq("beat_nbytes", out_nbytes, exp.nb);
            check_eq("beat_last", out_last, exp.last);
          end
        end
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin
    bit seen;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    set_fields(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_nbytes", out_nbytes, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_sizes", sizes, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    reset_n = 1'b1;
    mon_en  = 1;
    @(posedge clk);
    #1;

    // Single-byte FCS.
    send(1'b1, 1'b0, 8'h00, 32'h0, 64'h40, 2'd0, 8'h01);
    wait_done();

    // Window, 2-byte dictionary, offset FCS.
    send(1'b0, 1'b0, 8'h58, 32'h1234, 64'h1000, 2'd1, 8'hA2);
    wait_done();

    // Odd length, with a start coinciding with the final handshake.
    send(1'b1, 1'b0, 8'h00, 32'h0A, 64'h05, 2'd0, 8'h11);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) seen = 1;
    end
    check_eq("saw_last", seen, 1);
    set_fields(1'b1, 1'b0, 8'h00, 32'h0, 64'h40, 2'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("start_on_last_busy", busy, 0);
    check_eq("start_on_last_sizes", sizes, 8'h11);
    @(posedge clk);
    #1;
    check_eq("start_on_last_valid", out_valid, 0);
    wait_done();

    // Backpressure after the first beat.
    send(1'b1, 1'b0, 8'h00, 32'h0, 64'h40, 2'd0, 8'h01);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_data", out_data, 16'h2FFD);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_done();

    // Start while busy is ignored.
    send(1'b0, 1'b0, 8'h58, 32'h1234, 64'h1000, 2'd1, 8'hA2);
    set_fields(1'b1, 1'b0, 8'h00, 32'h0A, 64'h05, 2'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_start_sizes", sizes, 8'hA2);
    check_eq("busy_start_error", error, 0);
    wait_done();

    // FCS flag 1 with a value below the offset.
`ifdef FCS_AUTO_SIZE_EN
    send(1'b0, 1'b0, 8'h00, 32'h0, 64'h50, 2'd1, 8'h84);
`else
    send(1'b0, 1'b0, 8'h00, 32'h0, 64'h50, 2'd1, 8'hA2);
`endif
    wait_done();

    // Reset during the second beat, then a clean header.
    send(1'b0, 1'b0, 8'h58, 32'h1234, 64'h1000, 2'd1, 8'hA2);
    @(posedge clk);
    #1;
    check_eq("pre_reset_data", out_data, 16'h2FFD);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_data", out_data, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_sizes", sizes, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 8'h00, 32'h0, 64'h40, 2'd0, 8'h01);
    check_eq("post_reset_first", out_data, 16'h28B5);
    wait_done();

    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
